// File: rtl/uart_freq_tx.sv
// UART transmitter for 16-bit DDS frequency words: low byte frame, optional idle gap, high byte frame.
// Each 11-bit frame is start(0), byte-number bit, d0..d7 LSB first, stop(1).
module uart_freq_tx #(
    parameter int unsigned CLKS_PER_BIT = 521,
    parameter int unsigned GAP_BITS     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic [15:0] word_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // Only reachable when GAP_BITS > 0, so the wrap for GAP_BITS == 0 is harmless.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_BYTENUM = 3'd2,
        S_DATA    = 3'd3,
        S_STOP    = 3'd4,
        S_GAP     = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               byte_sel_q, byte_sel_d;
    logic [15:0]        shadow_q, shadow_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            gap_q      <= '0;
            byte_sel_q <= 1'b0;
            shadow_q   <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            gap_q      <= gap_d;
            byte_sel_q <= byte_sel_d;
            shadow_q   <= shadow_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        gap_d      = gap_q;
        byte_sel_d = byte_sel_q;
        shadow_d   = shadow_q;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (word_valid && ready_q) begin
                    shadow_d   = word_data;
                    byte_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_BYTENUM;
            end
            S_BYTENUM: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(7)) state_d = S_STOP;
                    else                        bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        gap_d      = '0;
                        state_d    = (GAP_BITS > 0) ? S_GAP : S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (gap_q == GAP_LAST) state_d = S_START;
                    else                   gap_d   = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the upcoming state so tx leads with no extra cycle
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_START:   tx_d = 1'b0;
            S_BYTENUM: tx_d = byte_sel_d;
            S_DATA:    tx_d = shadow_d[{byte_sel_d, bit_idx_d}];
            default:   tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign word_ready = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_uart_freq_tx.sv
// Directed bench for uart_freq_tx: one instance at 8 clk/bit with a 1-bit gap, one at 4 clk/bit with no gap.
module tb_uart_freq_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic [15:0] word_data;
    logic        sel;

    logic valid_a, ready_a, tx_a, busy_a, done_a;
    logic valid_b, ready_b, tx_b, busy_b, done_b;
    logic ready_o, tx_o, busy_o, done_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign valid_a = word_valid & ~sel;
    assign valid_b = word_valid & sel;
    assign ready_o = sel ? ready_b : ready_a;
    assign tx_o    = sel ? tx_b    : tx_a;
    assign busy_o  = sel ? busy_b  : busy_a;
    assign done_o  = sel ? done_b  : done_a;

    uart_freq_tx #(.CLKS_PER_BIT(8), .GAP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .word_valid(valid_a), .word_ready(ready_a),
        .word_data(word_data), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_freq_tx #(.CLKS_PER_BIT(4), .GAP_BITS(0)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .word_valid(valid_b), .word_ready(ready_b),
        .word_data(word_data), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    // Expected line level per bit-time: bit b of the result is the level of bit-time b after accept.
    function automatic logic [31:0] model_seq(input logic [15:0] w, input int gap);
        logic [31:0] s;
        int p;
        s = '1;
        s[0] = 1'b0;
        s[1] = 1'b0;
        for (int i = 0; i < 8; i++) s[2 + i] = w[i];
        s[10] = 1'b1;
        p = 11 + gap;
        s[p]     = 1'b0;
        s[p + 1] = 1'b1;
        for (int i = 0; i < 8; i++) s[p + 2 + i] = w[8 + i];
        s[p + 10] = 1'b1;
        return s;
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic accept(input logic [15:0] w, input bit keep_valid);
        int n;
        n = 0;
        word_valid = 1'b1;
        word_data  = w;
        while (ready_o !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: word_ready=%b after %0d cycles, required 1", ready_o, n);
        end
        @(posedge clk);
        #1;
        word_valid = keep_valid;
    endtask

    // Walks cycles 1..done_cycle after accept, one check per bit-time plus the done cycle.
    task automatic observe(input logic [31:0] seq, input int cpb, input int done_cycle,
                           input bit drop_valid, input string name);
        logic bad;
        logic [3:0] got;
        int b;
        bad = 1'b0;
        got = '0;
        for (int c = 1; c < done_cycle; c++) begin
            @(negedge clk);
            if (drop_valid && c == done_cycle - 1) word_valid = 1'b0;
            b = (c - 1) / cpb;
            if (!bad && (tx_o !== seq[b] || busy_o !== 1'b1 || done_o !== 1'b0 || ready_o !== 1'b0)) begin
                bad = 1'b1;
                got = {tx_o, busy_o, done_o, ready_o};
            end
            if (c % cpb == 0) begin
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL %s bit %0d cycle %0d: tx/busy/done/ready=%b, required %b100",
                             name, b, c, got, seq[b]);
                end
                bad = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({done_o, ready_o, busy_o, tx_o} !== 4'b1101) begin
            failures++;
            $display("FAIL %s done_cycle %0d: done/ready/busy/tx=%b, required 1101",
                     name, done_cycle, {done_o, ready_o, busy_o, tx_o});
        end
    endtask

    task automatic test_reset;
        sel        = 1'b0;
        rst_n      = 1'b0;
        word_valid = 1'b1;
        word_data  = 16'h1234;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_o !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", tx_o); end
        checks++;
        if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b, required 1", ready_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
        checks++;
        if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %b, required 0", done_o); end
        word_valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, tx_o} !== 2'b01) begin
            failures++;
            $display("FAIL reset_no_accept: busy/tx=%b, required 01", {busy_o, tx_o});
        end
    endtask

    task automatic test_single;
        logic        hand [23] = '{0,0, 0,0,1,0,1,1,0,0, 1,  1,  0,1, 0,1,0,0,1,0,0,0, 1};
        logic [31:0] seq;
        seq = '1;
        for (int i = 0; i < 23; i++) seq[i] = hand[i];
        accept(16'h1234, 1'b0);
        observe(seq, 8, 185, 1'b0, "single_1234");
        @(negedge clk);
        checks++;
        if ({done_o, ready_o, tx_o} !== 3'b011) begin
            failures++;
            $display("FAIL single_done_pulse: done/ready/tx=%b, required 011", {done_o, ready_o, tx_o});
        end
    endtask

    task automatic test_back_to_back;
        accept(16'h0000, 1'b1);
        word_data = 16'hFFFF;
        observe(model_seq(16'h0000, 1), 8, 185, 1'b0, "b2b_first");
        accept(16'hFFFF, 1'b0);
        observe(model_seq(16'hFFFF, 1), 8, 185, 1'b0, "b2b_second");
        @(negedge clk);
    endtask

    task automatic test_busy_protect;
        accept(16'hA5C3, 1'b1);
        word_data = 16'h0000;
        observe(model_seq(16'hA5C3, 1), 8, 185, 1'b1, "busy_a5c3");
        @(negedge clk);
        checks++;
        if ({busy_o, ready_o, tx_o} !== 3'b011) begin
            failures++;
            $display("FAIL busy_no_extra_accept: busy/ready/tx=%b, required 011", {busy_o, ready_o, tx_o});
        end
    endtask

    task automatic test_reset_mid;
        accept(16'h0000, 1'b0);
        repeat (129) @(negedge clk);
        checks++;
        if ({tx_o, busy_o} !== 2'b01) begin
            failures++;
            $display("FAIL mid_pre_reset: tx/busy=%b, required 01", {tx_o, busy_o});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_o, busy_o, ready_o, done_o} !== 4'b1010) begin
            failures++;
            $display("FAIL mid_async_reset: tx/busy/ready/done=%b, required 1010",
                     {tx_o, busy_o, ready_o, done_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        accept(16'h00FF, 1'b0);
        observe(model_seq(16'h00FF, 1), 8, 185, 1'b0, "after_reset_00ff");
        @(negedge clk);
    endtask

    task automatic test_gap0;
        sel = 1'b1;
        @(negedge clk);
        accept(16'h8001, 1'b0);
        observe(model_seq(16'h8001, 0), 4, 89, 1'b0, "gap0_8001");
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        sel        = 1'b0;
        rst_n      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_protect();
        test_reset_mid();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
